// File: rtl/vita49_tsgen.sv
// vita49_tsgen: VITA-49 timestamp generator.
// NUM_CH independent TSI/TSF counter pairs share one synchronised PPS
// reference. The block supports an armed TSI load on the next PPS, a
// per-channel TSF mode, a per-channel samples-per-second measurement and
// sticky PPS loss detection.
module vita49_tsgen #(
    parameter int NUM_CH      = 2,
    parameter int TSI_W       = 32,
    parameter int TSF_W       = 64,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int PPS_TIMEOUT = 100000000
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    pps_in,
    input  logic [NUM_CH-1:0]       samp_en,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       tsf_mode,
    input  logic [TSI_W-1:0]        tsi_prog,
    input  logic                    tsi_load,
    output logic                    tsi_armed,
    input  logic                    clear_lost,
    output logic [NUM_CH*TSI_W-1:0] tsi,
    output logic [NUM_CH*TSF_W-1:0] tsf,
    output logic [NUM_CH*CNT_W-1:0] tsf_last_sec,
    output logic                    pps_tick,
    output logic                    pps_lost
);

    localparam int                LOST_W   = $clog2(PPS_TIMEOUT + 1);
    localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(PPS_TIMEOUT);
    localparam logic [LOST_W-1:0] LOST_SET = LOST_W'(PPS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  SEC_MAX  = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d_q;
    logic                   pps_edge;
    logic                   pps_tick_q;

    logic [TSI_W-1:0] tsi_q  [NUM_CH];
    logic [TSI_W-1:0] tsi_d  [NUM_CH];
    logic [TSF_W-1:0] tsf_q  [NUM_CH];
    logic [TSF_W-1:0] tsf_d  [NUM_CH];
    logic [CNT_W-1:0] sec_q  [NUM_CH];
    logic [CNT_W-1:0] sec_d  [NUM_CH];
    logic [CNT_W-1:0] last_q [NUM_CH];
    logic [CNT_W-1:0] last_d [NUM_CH];
    logic [NUM_CH-1:0] samp_ok;

    logic [TSI_W-1:0]  shadow_q, shadow_d;
    logic              armed_q, armed_d;
    logic [LOST_W-1:0] lost_cnt_q, lost_cnt_d;
    logic              pps_lost_q, pps_lost_d;

    // Synchronise pps_in; reset to 1 so a level already high at release is not an edge.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sync_q     <= '1;
            sync_d_q   <= 1'b1;
            pps_tick_q <= 1'b0;
        end else begin
            // NOTE: every flop uses <= so all registers sample pre-edge values together.
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pps_in};
            sync_d_q   <= sync_q[SYNC_STAGES-1];
            pps_tick_q <= pps_edge;
        end
    end

    assign pps_edge = sync_q[SYNC_STAGES-1] & ~sync_d_q;
    assign samp_ok  = samp_en & enable;

    // Per-channel next-state for TSI, TSF and the samples-per-second measurement.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            // NOTE: defaults first so no path leaves a variable unassigned (no latch).
            tsi_d[c]  = tsi_q[c];
            tsf_d[c]  = tsf_q[c];
            sec_d[c]  = sec_q[c];
            last_d[c] = last_q[c];
            if (pps_edge) begin
                // A sample coincident with the edge belongs to the new second.
                last_d[c] = sec_q[c];
                sec_d[c]  = CNT_W'(samp_ok[c]);
                if (armed_q) begin
                    tsi_d[c] = shadow_q;
                    tsf_d[c] = TSF_W'(samp_en[c]);
                end else if (enable[c]) begin
                    tsi_d[c] = tsi_q[c] + TSI_W'(1);
                    tsf_d[c] = tsf_mode[c] ? TSF_W'(samp_en[c])
                                           : tsf_q[c] + TSF_W'(samp_en[c]);
                end
            end else begin
                tsf_d[c] = tsf_q[c] + TSF_W'(samp_ok[c]);
                if (samp_ok[c] && (sec_q[c] != SEC_MAX)) begin
                    sec_d[c] = sec_q[c] + CNT_W'(1);
                end
            end
        end
    end

    // Channel counter registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tsi_q[c]  <= '0;
                tsf_q[c]  <= '0;
                sec_q[c]  <= '0;
                last_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                tsi_q[c]  <= tsi_d[c];
                tsf_q[c]  <= tsf_d[c];
                sec_q[c]  <= sec_d[c];
                last_q[c] <= last_d[c];
            end
        end
    end

    // Arming: a load coincident with an edge misses that edge and waits for the next one.
    always_comb begin
        shadow_d = shadow_q;
        armed_d  = armed_q;
        if (tsi_load) begin
            shadow_d = tsi_prog;
            armed_d  = 1'b1;
        end else if (pps_edge) begin
            armed_d  = 1'b0;
        end
    end

    // Loss detection: saturating clock count since the last edge; set is a single event.
    always_comb begin
        lost_cnt_d = lost_cnt_q;
        pps_lost_d = pps_lost_q;
        if (pps_edge) begin
            lost_cnt_d = '0;
        end else if (lost_cnt_q != LOST_MAX) begin
            lost_cnt_d = lost_cnt_q + LOST_W'(1);
        end
        if (clear_lost) begin
            pps_lost_d = 1'b0;
        end
        if (!pps_edge && (lost_cnt_q == LOST_SET)) begin
            pps_lost_d = 1'b1;
        end
    end

    // Shadow, armed flag and loss state registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            shadow_q   <= '0;
            armed_q    <= 1'b0;
            lost_cnt_q <= '0;
            pps_lost_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            armed_q    <= armed_d;
            lost_cnt_q <= lost_cnt_d;
            pps_lost_q <= pps_lost_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign tsi[c*TSI_W +: TSI_W]          = tsi_q[c];
        assign tsf[c*TSF_W +: TSF_W]          = tsf_q[c];
        assign tsf_last_sec[c*CNT_W +: CNT_W] = last_q[c];
    end

    assign tsi_armed = armed_q;
    assign pps_tick  = pps_tick_q;
    assign pps_lost  = pps_lost_q;

endmodule
